// File: rtl/conv_frame_encoder.sv
// Framed K=5 rate-1/2 convolutional encoder: serial bits in, 2-bit symbols out,
// four zero tail symbols per frame so every frame terminates in state 0.
module conv_frame_encoder #(
    parameter int unsigned FRAME_LEN = 32,
    parameter logic [4:0]  G0        = 5'b11101,
    parameter logic [4:0]  G1        = 5'b10011
) (
    input  logic       clk,
    input  logic       res,
    input  logic       in_bit,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [1:0] sym_out,
    output logic       sym_valid,
    input  logic       sym_ready,
    output logic       sym_first,
    output logic       sym_last,
    output logic       busy
);
    localparam int unsigned   CW       = $clog2(FRAME_LEN + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(FRAME_LEN);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        TAIL = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    s_q, s_d;
    logic [CW-1:0] bcnt_q, bcnt_d;
    logic [1:0]    tcnt_q, tcnt_d;
    logic [1:0]    sym_q, sym_d;
    logic          vld_q, vld_d;
    logic          first_q, first_d;
    logic          last_q, last_d;
    logic          slot_free;
    logic [CW-1:0] bcnt_inc;

    // Window is {s, b}: bit 0 is the newest input, bit 4 the oldest.
    function automatic logic [1:0] encode(input logic [3:0] s, input logic b);
        logic [4:0] w;
        w = {s, b};
        return {^(w & G1), ^(w & G0)};
    endfunction

    always_comb begin
        state_d   = state_q;
        s_d       = s_q;
        bcnt_d    = bcnt_q;
        tcnt_d    = tcnt_q;
        sym_d     = sym_q;
        first_d   = first_q;
        last_d    = last_q;
        vld_d     = vld_q;
        in_ready  = 1'b0;
        slot_free = !vld_q || sym_ready;
        bcnt_inc  = bcnt_q + CW'(1);

        if (sym_ready) begin
            vld_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                in_ready = res && slot_free;
                if (in_valid && in_ready) begin
                    sym_d   = encode(4'd0, in_bit);
                    vld_d   = 1'b1;
                    first_d = 1'b1;
                    last_d  = 1'b0;
                    s_d     = {3'd0, in_bit};
                    bcnt_d  = CW'(1);
                    state_d = (FRAME_LEN == 1) ? TAIL : DATA;
                end
            end
            DATA: begin
                in_ready = res && slot_free;
                if (in_valid && in_ready) begin
                    sym_d   = encode(s_q, in_bit);
                    vld_d   = 1'b1;
                    first_d = 1'b0;
                    last_d  = 1'b0;
                    s_d     = {s_q[2:0], in_bit};
                    bcnt_d  = bcnt_inc;
                    if (bcnt_inc == LAST_CNT) begin
                        state_d = TAIL;
                    end
                end
            end
            TAIL: begin
                if (slot_free) begin
                    sym_d   = encode(s_q, 1'b0);
                    vld_d   = 1'b1;
                    first_d = 1'b0;
                    if (tcnt_q == 2'd3) begin
                        // Frame closes here so the next bit can be taken while this symbol is presented.
                        last_d  = 1'b1;
                        s_d     = 4'd0;
                        tcnt_d  = 2'd0;
                        bcnt_d  = '0;
                        state_d = IDLE;
                    end else begin
                        last_d = 1'b0;
                        s_d    = {s_q[2:0], 1'b0};
                        tcnt_d = tcnt_q + 2'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_q <= IDLE;
            s_q     <= 4'd0;
            bcnt_q  <= '0;
            tcnt_q  <= 2'd0;
            sym_q   <= 2'd0;
            vld_q   <= 1'b0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            bcnt_q  <= bcnt_d;
            tcnt_q  <= tcnt_d;
            sym_q   <= sym_d;
            vld_q   <= vld_d;
            first_q <= first_d;
            last_q  <= last_d;
        end
    end

    assign sym_out   = sym_q;
    assign sym_valid = vld_q;
    assign sym_first = first_q;
    assign sym_last  = last_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_conv_frame_encoder.sv
// Bench for conv_frame_encoder: three instances (FRAME_LEN 1, 4, 32) checked against
// a direct convolution-sum model of the framed code.
`timescale 1ns/1ps
module tb_conv_frame_encoder;
    localparam int NI = 3;
    localparam logic [4:0] G0 = 5'b11101;
    localparam logic [4:0] G1 = 5'b10011;
    localparam logic [1:0] IMP [8] = '{2'b11, 2'b10, 2'b01, 2'b01, 2'b11, 2'b00, 2'b00, 2'b00};

    logic       clk = 1'b0;
    logic       res;
    logic       in_bit    [NI];
    logic       in_valid  [NI];
    logic       in_ready  [NI];
    logic [1:0] sym_out   [NI];
    logic       sym_valid [NI];
    logic       sym_ready [NI];
    logic       sym_first [NI];
    logic       sym_last  [NI];
    logic       busy      [NI];

    int n_cmp;
    int n_bad;
    logic       src_q [$];
    logic [3:0] exp_q [$];
    logic [3:0] got_q [$];
    int   stab_err;
    int   span;
    logic hold_vld;
    logic hold_busy;

    always #5 clk = ~clk;

    conv_frame_encoder #(.FRAME_LEN(1)) u_f1 (
        .clk(clk), .res(res), .in_bit(in_bit[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .sym_out(sym_out[0]), .sym_valid(sym_valid[0]), .sym_ready(sym_ready[0]),
        .sym_first(sym_first[0]), .sym_last(sym_last[0]), .busy(busy[0]));
    conv_frame_encoder #(.FRAME_LEN(4)) u_f4 (
        .clk(clk), .res(res), .in_bit(in_bit[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .sym_out(sym_out[1]), .sym_valid(sym_valid[1]), .sym_ready(sym_ready[1]),
        .sym_first(sym_first[1]), .sym_last(sym_last[1]), .busy(busy[1]));
    conv_frame_encoder #(.FRAME_LEN(32)) u_f32 (
        .clk(clk), .res(res), .in_bit(in_bit[2]), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .sym_out(sym_out[2]), .sym_valid(sym_valid[2]), .sym_ready(sym_ready[2]),
        .sym_first(sym_first[2]), .sym_last(sym_last[2]), .busy(busy[2]));

    // Each symbol n of a frame is the generator-weighted XOR of data bits n-4..n (zero outside the frame).
    function automatic void build_exp(input int len, input int nframes);
        logic s0, s1, b;
        int idx;
        exp_q.delete();
        for (int f = 0; f < nframes; f++) begin
            for (int n = 0; n < len + 4; n++) begin
                s0 = 1'b0;
                s1 = 1'b0;
                for (int j = 0; j < 5; j++) begin
                    idx = n - j;
                    if (idx >= 0 && idx < len) begin
                        b  = src_q[f * len + idx];
                        s0 = s0 ^ (G0[j] & b);
                        s1 = s1 ^ (G1[j] & b);
                    end
                end
                exp_q.push_back({(n == 0), (n == len + 3), s1, s0});
            end
        end
    endfunction

    // Streams src_q into instance k and collects handshaken symbols {first,last,sym} into got_q.
    task automatic stream(input int k, input int pv, input int pr, input int hold_at,
                          input int hold_len, input int budget);
        int cyc, bi, hcnt, first_cyc, last_cyc, nsym;
        logic hold_prev, sampled;
        logic [3:0] prev, cur;
        nsym = exp_q.size();
        got_q.delete();
        stab_err = 0; bi = 0; hcnt = 0; cyc = 0; hold_prev = 1'b0; sampled = 1'b0;
        first_cyc = -1; last_cyc = -1; prev = '0;
        while (got_q.size() < nsym && cyc < budget) begin
            if (bi == hold_at && hcnt < hold_len) begin
                in_valid[k] = 1'b0;
                hcnt++;
            end else begin
                in_valid[k] = (bi < src_q.size()) && ($urandom_range(99) < pv);
            end
            in_bit[k]    = in_valid[k] ? src_q[bi] : 1'($urandom);
            sym_ready[k] = ($urandom_range(99) < pr);
            @(negedge clk);
            cur = {sym_first[k], sym_last[k], sym_out[k]};
            if (hold_prev && (sym_valid[k] !== 1'b1 || cur !== prev)) stab_err++;
            hold_prev = sym_valid[k] && !sym_ready[k];
            prev = cur;
            if (sym_valid[k] && sym_ready[k]) begin
                got_q.push_back(cur);
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
            end
            if (in_valid[k] && in_ready[k]) bi++;
            if (hold_len > 0 && hcnt == hold_len && !sampled) begin
                hold_vld  = sym_valid[k];
                hold_busy = busy[k];
                sampled   = 1'b1;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        in_valid[k]  = 1'b0;
        sym_ready[k] = 1'b1;
        span = last_cyc - first_cyc + 1;
    endtask

    task automatic test_reset();
        res = 1'b0;
        for (int k = 0; k < NI; k++) begin
            in_valid[k] = 1'b1; in_bit[k] = 1'b1; sym_ready[k] = 1'b1;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            n_cmp++;
            if ({in_ready[k], sym_valid[k], sym_first[k], sym_last[k], busy[k], sym_out[k]} !== 7'b0) begin
                n_bad++;
                $display("FAIL reset_outputs k=%0d got rdy=%b vld=%b first=%b last=%b busy=%b sym=%b, want all 0",
                         k, in_ready[k], sym_valid[k], sym_first[k], sym_last[k], busy[k], sym_out[k]);
            end
            in_valid[k] = 1'b0;
        end
        @(posedge clk);
        #1;
        res = 1'b1;
        @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            n_cmp++;
            if ({in_ready[k], busy[k], sym_valid[k]} !== 3'b100) begin
                n_bad++;
                $display("FAIL reset_release k=%0d got rdy=%b busy=%b vld=%b, want 1 0 0",
                         k, in_ready[k], busy[k], sym_valid[k]);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_impulse_len1();
        in_valid[0] = 1'b1; in_bit[0] = 1'b1; sym_ready[0] = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({in_ready[0], busy[0]} !== 2'b10) begin
            n_bad++;
            $display("FAIL imp1_accept got rdy=%b busy=%b, want 1 0", in_ready[0], busy[0]);
        end
        @(posedge clk);
        #1;
        in_valid[0] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({sym_valid[0], sym_first[0], sym_last[0], busy[0], sym_out[0]} !==
                {1'b1, (i == 0), (i == 4), (i < 4), IMP[i]}) begin
                n_bad++;
                $display("FAIL imp1_sym i=%0d got vld=%b first=%b last=%b busy=%b sym=%b, want 1 %b %b %b %b",
                         i, sym_valid[0], sym_first[0], sym_last[0], busy[0], sym_out[0],
                         (i == 0), (i == 4), (i < 4), IMP[i]);
            end
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        n_cmp++;
        if (sym_valid[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL imp1_drain got vld=%b, want 0", sym_valid[0]);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_len4();
        for (int n = 0; n < 8; n++) begin
            in_valid[1]  = 1'b1;
            in_bit[1]    = (n == 0 || n >= 4);
            sym_ready[1] = 1'b1;
            @(negedge clk);
            n_cmp++;
            if (in_ready[1] !== (n < 4)) begin
                n_bad++;
                $display("FAIL len4_in_ready n=%0d got %b, want %b", n, in_ready[1], (n < 4));
            end
            if (n >= 1) begin
                n_cmp++;
                if ({sym_valid[1], sym_first[1], sym_last[1], sym_out[1]} !== {1'b1, (n == 1), 1'b0, IMP[n-1]}) begin
                    n_bad++;
                    $display("FAIL len4_sym i=%0d got vld=%b first=%b last=%b sym=%b, want 1 %b 0 %b",
                             n - 1, sym_valid[1], sym_first[1], sym_last[1], sym_out[1], (n == 1), IMP[n-1]);
                end
            end
            @(posedge clk);
            #1;
        end
        in_valid[1] = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({sym_valid[1], sym_first[1], sym_last[1], sym_out[1], in_ready[1], busy[1]} !== {1'b1, 1'b0, 1'b1, IMP[7], 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL len4_last got vld=%b first=%b last=%b sym=%b rdy=%b busy=%b, want 1 0 1 00 1 0",
                     sym_valid[1], sym_first[1], sym_last[1], sym_out[1], in_ready[1], busy[1]);
        end
        @(posedge clk);
        #1;
        // A second identical frame must match the zero-start model, which requires s back at 0.
        src_q = '{1'b1, 1'b0, 1'b0, 1'b0};
        build_exp(4, 1);
        stream(1, 100, 100, -1, 0, 100);
        n_cmp++;
        if (got_q.size() != exp_q.size()) begin
            n_bad++;
            $display("FAIL len4_repeat_count got %0d symbols, want %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i] || got_q[i][1:0] !== IMP[i]) begin
                n_bad++;
                $display("FAIL len4_repeat_sym i=%0d got %b, want %b", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_zero_back_to_back();
        int nf, nl, nz;
        src_q.delete();
        for (int i = 0; i < 32; i++) src_q.push_back(1'b0);
        for (int i = 0; i < 32; i++) src_q.push_back(1'($urandom));
        build_exp(32, 2);
        stream(2, 100, 100, -1, 0, 500);
        n_cmp++;
        if (got_q.size() != exp_q.size()) begin
            n_bad++;
            $display("FAIL b2b_count got %0d symbols, want %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin
                n_bad++;
                $display("FAIL b2b_sym i=%0d got %b, want %b", i, got_q[i], exp_q[i]);
            end
        end
        nf = 0; nl = 0; nz = 0;
        for (int i = 0; i < 36 && i < got_q.size(); i++) begin
            nf += int'(got_q[i][3]);
            nl += int'(got_q[i][2]);
            if (got_q[i][1:0] != 2'b00) nz++;
        end
        n_cmp++;
        if (nf != 1 || nl != 1 || nz != 0) begin
            n_bad++;
            $display("FAIL zero_frame_markers got first=%0d last=%0d nonzero=%0d, want 1 1 0", nf, nl, nz);
        end
        n_cmp++;
        if (span != 72) begin
            n_bad++;
            $display("FAIL b2b_span got %0d cycles for 72 symbols, want 72", span);
        end
    endtask

    task automatic test_backpressure();
        int nframes, len;
        for (int k = 0; k < NI; k++) begin
            len     = (k == 0) ? 1 : ((k == 1) ? 4 : 32);
            nframes = (k == 0) ? 30 : 100;
            src_q.delete();
            for (int i = 0; i < len * nframes; i++) src_q.push_back(1'($urandom));
            build_exp(len, nframes);
            stream(k, 70, 50, -1, 0, 40000);
            n_cmp++;
            if (got_q.size() != exp_q.size()) begin
                n_bad++;
                $display("FAIL bp_count k=%0d got %0d symbols, want %0d", k, got_q.size(), exp_q.size());
            end
            for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
                n_cmp++;
                if (got_q[i] !== exp_q[i]) begin
                    n_bad++;
                    $display("FAIL bp_sym k=%0d i=%0d got %b, want %b", k, i, got_q[i], exp_q[i]);
                end
            end
            n_cmp++;
            if (stab_err != 0) begin
                n_bad++;
                $display("FAIL bp_stall_hold k=%0d got %0d changes while stalled, want 0", k, stab_err);
            end
        end
    endtask

    task automatic test_reset_midframe();
        int k, len, nacc, extra, acc, guard;
        for (int sc = 0; sc < 2; sc++) begin
            k     = (sc == 0) ? 2 : 1;
            len   = (sc == 0) ? 32 : 4;
            nacc  = (sc == 0) ? 9 : 4;
            extra = (sc == 0) ? 0 : 1;
            acc = 0; guard = 0;
            while (acc < nacc && guard < 200) begin
                in_valid[k] = 1'b1; in_bit[k] = 1'($urandom); sym_ready[k] = 1'b1;
                @(negedge clk);
                if (in_valid[k] && in_ready[k]) acc++;
                @(posedge clk);
                #1;
                guard++;
            end
            in_valid[k] = 1'b0;
            repeat (extra) @(posedge clk);
            #1;
            n_cmp++;
            if (acc != nacc || busy[k] !== 1'b1) begin
                n_bad++;
                $display("FAIL rstmid_setup k=%0d got accepted=%0d busy=%b, want %0d 1", k, acc, busy[k], nacc);
            end
            res = 1'b0;
            #1;
            n_cmp++;
            if ({in_ready[k], sym_valid[k], sym_first[k], sym_last[k], busy[k], sym_out[k]} !== 7'b0) begin
                n_bad++;
                $display("FAIL rstmid_outputs k=%0d got rdy=%b vld=%b first=%b last=%b busy=%b sym=%b, want all 0",
                         k, in_ready[k], sym_valid[k], sym_first[k], sym_last[k], busy[k], sym_out[k]);
            end
            @(posedge clk);
            #1;
            res = 1'b1;
            src_q.delete();
            src_q.push_back(1'b1);
            for (int i = 1; i < len; i++) src_q.push_back(1'b0);
            build_exp(len, 1);
            stream(k, 100, 100, -1, 0, 200);
            n_cmp++;
            if (got_q.size() != exp_q.size()) begin
                n_bad++;
                $display("FAIL rstmid_count k=%0d got %0d symbols, want %0d", k, got_q.size(), exp_q.size());
            end
            for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
                n_cmp++;
                if (got_q[i] !== exp_q[i] || (i < 8 && got_q[i][1:0] !== IMP[i])) begin
                    n_bad++;
                    $display("FAIL rstmid_sym k=%0d i=%0d got %b, want %b", k, i, got_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_input_stall();
        src_q.delete();
        for (int i = 0; i < 32; i++) src_q.push_back(1'($urandom));
        build_exp(32, 1);
        hold_vld = 1'bx; hold_busy = 1'bx;
        stream(2, 100, 100, 10, 20, 300);
        n_cmp++;
        if ({hold_vld, hold_busy} !== 2'b01) begin
            n_bad++;
            $display("FAIL stall_state got vld=%b busy=%b after 20 idle cycles, want 0 1", hold_vld, hold_busy);
        end
        n_cmp++;
        if (got_q.size() != exp_q.size()) begin
            n_bad++;
            $display("FAIL stall_count got %0d symbols, want %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin
                n_bad++;
                $display("FAIL stall_sym i=%0d got %b, want %b", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        res   = 1'b0;
        for (int k = 0; k < NI; k++) begin
            in_valid[k] = 1'b0; in_bit[k] = 1'b0; sym_ready[k] = 1'b0;
        end
        #2;
        test_reset();
        test_impulse_len1();
        test_len4();
        test_zero_back_to_back();
        test_backpressure();
        test_reset_midframe();
        test_input_stall();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/conv_frame_encoder.md
# conv_frame_encoder

Framed, flow-controlled transmitter for the K=5, rate-1/2 convolutional code used by the team's Viterbi decoder (generators 5'b11101 / 5'b10011). It accepts a serial bit stream with a valid/ready handshake, encodes fixed-length frames, and appends 4 zero tail bits so every frame ends in state 0. It emits 2-bit symbols with first/last markers on a valid/ready output. It sits between the payload source and the channel/decoder input, replacing the free-running encoder for framed traffic.

## Interface
- FRAME_LEN, 32: data bits per frame, ≥1.
- G0, 5'b11101: generator for sym_out[0].
- G1, 5'b10011: generator for sym_out[1].
- clk  input  1  single clock; all logic on posedge.
- res  input  1  reset; asynchronous, active-low.
- in_bit  input  1  payload bit.
- in_valid  input  1  in_bit is valid.
- in_ready  output  1  block accepts in_bit this cycle.
- sym_out  output  2  encoded symbol, registered.
- sym_valid  output  1  sym_out holds a valid symbol.
- sym_ready  input  1  downstream takes the symbol this cycle.
- sym_first  output  1  symbol is the first of a frame; qualified by sym_valid.
- sym_last  output  1  symbol is the last tail symbol of a frame; qualified by sym_valid.
- busy  output  1  frame in progress (DATA or TAIL state).

## Operation
- State register s[3:0] holds the previous 4 encoder input bits; s[0] is the most recent. Window w = {s, b} for input b, so w[0]=b and w[4] is the oldest bit. sym[0] = ^(w & G0), sym[1] = ^(w & G1). After each encoded bit, s <= w[3:0].
- Output slot is free when !sym_valid || sym_ready. Loading the slot sets sym_valid=1. A handshake without a new load clears sym_valid.
- FSM:
  - IDLE: in_ready = res && slot_free. On accept: encode in_bit with s=0, set sym_first=1, bit count = 1, go to DATA. If FRAME_LEN==1, go directly to TAIL.
  - DATA: in_ready = res && slot_free. Each accept encodes in_bit and increments the bit count. The accept that makes count == FRAME_LEN goes to TAIL.
  - TAIL: in_ready = 0. Each cycle with slot_free, encode b=0 and increment the tail count (0..3). On the 4th tail symbol, set sym_last=1, clear s to 0, go to IDLE.
- sym_first and sym_last are registered with sym_out and hold their value while the symbol is stalled.
- busy = (state != IDLE).
- Bit counter width is $clog2(FRAME_LEN+1); the tail counter is 2 bits. Neither counter wraps mid-frame.
- A frame is always FRAME_LEN+4 symbols long, with exactly one sym_first and one sym_last.

## Timing
- Reset values (async, while res=0):
  - sym_out=0, sym_valid=0, sym_first=0, sym_last=0, busy=0, in_ready=0.
  - state IDLE, s=0, both counters 0.
- Latency: the symbol for a bit accepted at edge t is valid after edge t.
- Throughput: with sym_ready held 1 and in_valid held 1, one symbol per cycle. The 4 tail symbols follow the last data symbol with no gap.
- Back-to-back frames: the cycle the last tail symbol is presented, state is already IDLE. If sym_ready=1, the next frame's first bit is accepted in that same cycle, so there is zero idle cycles between frames.
- Backpressure: while sym_valid=1 and sym_ready=0, sym_out/first/last hold, in_ready=0, and TAIL does not advance.
- in_valid=0 in DATA: no symbol is generated, and state and count are held indefinitely.
- Reset asserted mid-frame: the frame is discarded immediately with no partial tail. After release the block is in IDLE, and the next accepted bit starts a new frame with sym_first=1 and s=0.

## Test plan
- Impulse, FRAME_LEN=1, in_bit=1 → sym_out sequence 11,10,01,01,11 on consecutive cycles (sym_ready=1); first on symbol 1, last on symbol 5; busy high from accept through the 4th tail load.
- FRAME_LEN=4, bits 1,0,0,0 → 11,10,01,01,11,00,00,00; in_ready=0 for the 4 tail cycles; final s=0.
- All-zero frame, FRAME_LEN=32 → 36 symbols of 00; exactly one first and one last; then a second frame accepted in the cycle its last symbol is presented, with no gap.
- Backpressure: random sym_ready (~50%) and in_valid (~70%) over 100 frames of random data → output equals the reference model's symbol stream; sym_out stable whenever sym_valid && !sym_ready; no symbol lost or duplicated.
- Reset asserted in the 10th data cycle and in the 2nd tail cycle → all outputs 0 during reset; the next frame after release reproduces the FRAME_LEN=4 impulse result exactly.
- Held in_valid=0 for 20 cycles mid-frame → sym_valid drops after drain, busy stays 1, and encoding resumes correctly when in_valid returns.
